scroll_direction_ctrl: RTL and testbench

SCROLL_DIRECTION_CTRL -- requirements
Module: scroll_direction_ctrl

---
 rtl/scroll_pkg.sv | 39 +++
 rtl/frame_tick_sync.sv | 23 ++
 rtl/scroll_direction_ctrl.sv | 99 +++++++++
 tb/tb_scroll_direction_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// scroll_pkg: shared direction/state types, keycodes, screen size and wrap helpers
package scroll_pkg;
  typedef enum logic [3:0] {
    DIR_NONE  = 4'b0000,
    DIR_LEFT  = 4'b0001,
    DIR_RIGHT = 4'b0010,
    DIR_DOWN  = 4'b0100,
    DIR_UP    = 4'b1000
  } dir_t;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HIT   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;
  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_PAUSE = 8'h13;
  localparam int X_DIM = 640;
  localparam int Y_DIM = 480;
  function automatic dir_t key_to_dir(input logic [7:0] k);
    return k == KEY_UP    ? DIR_UP    :
           k == KEY_DOWN  ? DIR_DOWN  :
           k == KEY_RIGHT ? DIR_RIGHT :
           k == KEY_LEFT  ? DIR_LEFT  : DIR_NONE;
  endfunction
  // 11-bit sums keep v+s (up to 1118) from aliasing past 1023
  function automatic logic [9:0] wrap_step(input logic [9:0] v, input logic [10:0] s,
                                           input logic [10:0] dim, input logic inc,
                                           input logic dec);
    logic [10:0] up;
    logic [10:0] dn;
    up = {1'b0, v} + s;
    dn = ({1'b0, v} < s) ? {1'b0, v} + dim - s : {1'b0, v} - s;
    return inc ? 10'(up >= dim ? up - dim : up) : dec ? 10'(dn) : v;
  endfunction
endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: two-flop synchroniser plus registered rising-edge pulse of frame_clk
module frame_tick_sync (
  input  logic vga_clk,
  input  logic reset,
  input  logic frame_clk,
  output logic frame_tick
);
  logic s1_q, s2_q, s3_q, tick_q;
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= frame_clk;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      tick_q <= s2_q & ~s3_q;
    end
  end
  assign frame_tick = tick_q;
endmodule

// File: rtl/scroll_direction_ctrl.sv
// scroll_direction_ctrl: keyboard-steered wrapping scroll offsets with collision freeze/restart.
// Define SCROLL_PAUSE_EN to make keycode 0x13 toggle RUN<->PAUSE.
module scroll_direction_ctrl
  import scroll_pkg::*;
#(
  parameter int RESTART_FRAMES = 120,
  parameter int SCROLL_STEP    = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       collided,
  output logic [3:0] direction,
  output logic [9:0] x_offset,
  output logic [9:0] y_offset,
  output logic [1:0] game_state,
  output logic       frame_tick
);
  localparam int CW = $clog2(RESTART_FRAMES + 2);
  localparam logic [10:0] STEP = 11'(SCROLL_STEP);
  state_t state_q, state_d;
  dir_t dir_q, dir_d, key_dir, step_dir;
  logic [9:0] x_q, x_d, y_q, y_d, x_mv, y_mv;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pause_key;
  frame_tick_sync u_sync (
    .vga_clk   (vga_clk),
    .reset     (reset),
    .frame_clk (frame_clk),
    .frame_tick(frame_tick)
  );
  assign key_dir = key_to_dir(keycode);
`ifdef SCROLL_PAUSE_EN
  assign pause_key = keycode == KEY_PAUSE;
`else
  assign pause_key = 1'b0;
`endif
  assign step_dir = (key_dir != DIR_NONE) ? key_dir : dir_q;
  assign x_mv = wrap_step(x_q, STEP, 11'(X_DIM), step_dir == DIR_RIGHT, step_dir == DIR_LEFT);
  assign y_mv = wrap_step(y_q, STEP, 11'(Y_DIM), step_dir == DIR_DOWN, step_dir == DIR_UP);
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      ST_IDLE: if (frame_tick && key_dir != DIR_NONE) begin
        state_d = ST_RUN;
        dir_d   = key_dir;
        x_d     = x_mv;
        y_d     = y_mv;
      end
      // collision beats a coincident tick
      ST_RUN: if (collided) begin
        state_d = ST_HIT;
        cnt_d   = CW'(RESTART_FRAMES);
      end else if (frame_tick && pause_key) begin
        state_d = ST_PAUSE;
      end else if (frame_tick) begin
        dir_d = step_dir;
        x_d   = x_mv;
        y_d   = y_mv;
      end
      ST_HIT: if (frame_tick) begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          dir_d   = DIR_NONE;
          x_d     = '0;
          y_d     = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PAUSE: state_d = (frame_tick && pause_key) ? ST_RUN : ST_PAUSE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_NONE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end
  assign direction  = dir_q;
  assign x_offset   = x_q;
  assign y_offset   = y_q;
  assign game_state = state_q;
endmodule

// File: tb/tb_scroll_direction_ctrl.sv
// tb_scroll_direction_ctrl: model-checked directed test of two scroll_direction_ctrl configurations
module tb_scroll_direction_ctrl;
  logic clk = 1'b0, reset = 1'b1, frame_clk = 1'b0, collided = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [3:0] dir_a, dir_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic [1:0] gs_a, gs_b;
  logic ft_a, ft_b;
  int n_vec = 0, n_err = 0;
`ifdef SCROLL_PAUSE_EN
  localparam bit PAUSE_ON = 1'b1;
`else
  localparam bit PAUSE_ON = 1'b0;
`endif
  always #5 clk = ~clk;
  scroll_direction_ctrl #(.RESTART_FRAMES(120), .SCROLL_STEP(1)) u_a (
    .vga_clk(clk), .reset(reset), .frame_clk(frame_clk), .keycode(keycode), .collided(collided),
    .direction(dir_a), .x_offset(x_a), .y_offset(y_a), .game_state(gs_a), .frame_tick(ft_a));
  scroll_direction_ctrl #(.RESTART_FRAMES(2), .SCROLL_STEP(479)) u_b (
    .vga_clk(clk), .reset(reset), .frame_clk(frame_clk), .keycode(keycode), .collided(collided),
    .direction(dir_b), .x_offset(x_b), .y_offset(y_b), .game_state(gs_b), .frame_tick(ft_b));
  // game: st 0 idle/1 run/2 hit/3 pause; dr 0 none/1 up/2 down/3 right/4 left
  typedef struct { int st; int dr; int x; int y; int cd; } mst_t;
  mst_t m_a, m_b;
  logic [2:0] hist;
  bit mtick = 1'b0, started = 1'b0;
  function automatic int key_dir(logic [7:0] k);
    return k == 8'h1A ? 1 : k == 8'h16 ? 2 : k == 8'h07 ? 3 : k == 8'h04 ? 4 : 0;
  endfunction
  function automatic logic [31:0] onehot(int d);
    return d == 1 ? 8 : d == 2 ? 4 : d == 3 ? 2 : d == 4 ? 1 : 0;
  endfunction
  function automatic mst_t move(mst_t c, int s);
    mst_t n;
    n = c;
    if (c.dr == 3) n.x = (c.x + s) % 640;
    if (c.dr == 4) n.x = (c.x - s + 640) % 640;
    if (c.dr == 2) n.y = (c.y + s) % 480;
    if (c.dr == 1) n.y = (c.y - s + 480) % 480;
    return n;
  endfunction
  function automatic mst_t advance(mst_t c, int s, int r, bit tick, logic [7:0] k, bit col);
    mst_t n;
    int kd;
    bit pk;
    n = c;
    kd = key_dir(k);
    pk = PAUSE_ON && k == 8'h13;
    if (c.st == 1 && col) begin
      n.st = 2;
      n.cd = r;
    end else if (tick) begin
      if (c.st == 0 && kd != 0) begin
        n.st = 1;
        n.dr = kd;
        n = move(n, s);
      end else if (c.st == 1 && pk) n.st = 3;
      else if (c.st == 1) begin
        if (kd != 0) n.dr = kd;
        n = move(n, s);
      end else if (c.st == 2 && c.cd == 0) n = '{0, 0, 0, 0, 0};
      else if (c.st == 2) n.cd = c.cd - 1;
      else if (c.st == 3 && pk) n.st = 1;
    end
    return n;
  endfunction
  // tick after edge k is fc(k-2) & ~fc(k-3); samples up to the reset edge count as 0
  always @(posedge clk) begin
    if (reset) begin
      hist    <= 3'b000;
      mtick   <= 1'b0;
      m_a     <= '{0, 0, 0, 0, 0};
      m_b     <= '{0, 0, 0, 0, 0};
      started <= 1'b1;
    end else begin
      m_a   <= advance(m_a, 1, 120, mtick, keycode, collided);
      m_b   <= advance(m_b, 479, 2, mtick, keycode, collided);
      hist  <= {hist[1:0], frame_clk};
      mtick <= hist[1] & ~hist[2];
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (started) begin
      chk("a_state", 32'(gs_a), m_a.st);
      chk("a_dir", 32'(dir_a), onehot(m_a.dr));
      chk("a_x", 32'(x_a), m_a.x);
      chk("a_y", 32'(y_a), m_a.y);
      chk("a_tick", 32'(ft_a), 32'(mtick));
      chk("b_state", 32'(gs_b), m_b.st);
      chk("b_dir", 32'(dir_b), onehot(m_b.dr));
      chk("b_x", 32'(x_b), m_b.x);
      chk("b_y", 32'(y_b), m_b.y);
      chk("b_tick", 32'(ft_b), 32'(mtick));
    end
  end
  // keycode differs from k on every cycle but the tick cycle
  task automatic frame(input logic [7:0] k, input logic col);
    logic [7:0] junk;
    junk = (k == 8'h07) ? 8'h04 : 8'h07;
    @(negedge clk);
    frame_clk = 1'b1;
    keycode = junk;
    @(negedge clk);
    chk("tick_c1", 32'(ft_a), 0);
    @(negedge clk);
    chk("tick_c2", 32'(ft_a), 0);
    @(negedge clk);
    chk("tick_c3", 32'(ft_a), 1);
    keycode = k;
    collided = col;
    @(negedge clk);
    chk("tick_c4", 32'(ft_a), 0);
    keycode = junk;
    collided = 1'b0;
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic hit_pulse();
    @(negedge clk);
    collided = 1'b1;
    @(negedge clk);
    collided = 1'b0;
  endtask
  logic [9:0] x_hold;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(gs_a), 0);
    chk("rst_dir", 32'(dir_a), 0);
    chk("rst_x", 32'(x_a), 0);
    chk("rst_tick", 32'(ft_a), 0);
    reset = 1'b0;
    frame(8'h00, 1'b0);
    chk("idle_nokey", 32'(gs_a), 0);
    frame(8'h04, 1'b0);
    chk("left_state", 32'(gs_a), 1);
    chk("left_dir", 32'(dir_a), 1);
    chk("left_x", 32'(x_a), 639);
    chk("left_x_s479", 32'(x_b), 161);
    frame(8'h07, 1'b0);
    chk("right_wrap_x", 32'(x_a), 0);
    chk("right_wrap_x_s479", 32'(x_b), 0);
    repeat (5) frame(8'h00, 1'b0);
    chk("hold_x", 32'(x_a), 5);
    chk("alias_x_s479", 32'(x_b), 475);
    frame(8'h1A, 1'b0);
    chk("up_dir", 32'(dir_a), 8);
    chk("up_y", 32'(y_a), 479);
    chk("up_y_s479", 32'(y_b), 1);
    frame(8'h16, 1'b0);
    chk("down_dir", 32'(dir_a), 4);
    chk("down_y", 32'(y_a), 0);
    chk("down_y_s479", 32'(y_b), 0);
    repeat (100) frame(8'h00, 1'b0);
    chk("y100", 32'(y_a), 100);
    frame(8'h1A, 1'b1);
    chk("col_tick_state", 32'(gs_a), 2);
    chk("col_tick_y", 32'(y_a), 100);
    chk("col_tick_dir", 32'(dir_a), 4);
    repeat (120) frame(8'h00, 1'b0);
    chk("hit_120", 32'(gs_a), 2);
    frame(8'h00, 1'b0);
    chk("hit_done_state", 32'(gs_a), 0);
    chk("hit_done_x", 32'(x_a), 0);
    chk("hit_done_y", 32'(y_a), 0);
    hit_pulse();
    chk("idle_ignores_col", 32'(gs_a), 0);
    frame(8'h04, 1'b0);
    hit_pulse();
    chk("midframe_hit", 32'(gs_a), 2);
    frame(8'h07, 1'b0);
    chk("hit_frozen_x", 32'(x_a), 639);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_hit_state", 32'(gs_a), 0);
    chk("rst_hit_x", 32'(x_a), 0);
    frame(8'h04, 1'b0);
    frame(8'h13, 1'b0);
`ifdef SCROLL_PAUSE_EN
    chk("pause_state", 32'(gs_a), 3);
    x_hold = x_a;
    hit_pulse();
    chk("pause_ignores_col", 32'(gs_a), 3);
    frame(8'h07, 1'b0);
    chk("pause_frozen_x", 32'(x_a), 32'(x_hold));
    frame(8'h13, 1'b0);
    chk("unpause_state", 32'(gs_a), 1);
    chk("unpause_dir", 32'(dir_a), 1);
`else
    x_hold = 10'd638;
    chk("no_pause_state", 32'(gs_a), 1);
    chk("no_pause_x", 32'(x_a), 32'(x_hold));
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
